// File: rtl/tpu_pkg.sv
// Shared TPU types and constants: drain FSM states, MXU geometry and precision modes.
package tpu_pkg;

  localparam int TPU_ROWS   = 16;
  localparam int TPU_BEAT_W = 128;

  localparam logic MODE_INT8  = 1'b0;
  localparam logic MODE_INT16 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/oram_drain_rowsel.sv
// Combinational beat select: picks the 128-bit slice of the MXU row buses for beat index b.
module oram_drain_rowsel
  import tpu_pkg::*;
#(
  parameter int ROWS   = TPU_ROWS,
  parameter int BEAT_W = TPU_BEAT_W,
  parameter int BIDX_W = $clog2(2 * ROWS)
) (
  input  logic [BIDX_W-1:0]        beat_i,
  input  logic                     mode_i,
  input  logic [ROWS*BEAT_W-1:0]   int8_rows_i,
  input  logic [ROWS*2*BEAT_W-1:0] int16_rows_i,
  output logic [BEAT_W-1:0]        data_o
);

  logic [BIDX_W-2:0] row8;

  // In int16 mode {row, half} is the beat index itself, so it addresses the bus directly.
  always_comb begin
    row8 = beat_i[BIDX_W-2:0];
    if (mode_i == MODE_INT16) begin
      data_o = int16_rows_i[int'(beat_i) * BEAT_W +: BEAT_W];
    end else begin
      data_o = int8_rows_i[int'(row8) * BEAT_W +: BEAT_W];
    end
  end

endmodule

// File: rtl/oram_drain.sv
// Drains MXU result rows into ORAM as registered 128-bit beats (int8: 1 beat/row, int16: 2).
// Optional per-row skip mask is enabled by defining ORAM_DRAIN_ROWMASK_EN.
module oram_drain
  import tpu_pkg::*;
#(
  parameter int ROWS   = TPU_ROWS,
  parameter int BEAT_W = TPU_BEAT_W,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lsu_drain_vld,
  output logic                     lsu_drain_rdy,
  input  logic                     lsu_drain_int16,
  input  logic [ADDR_W-1:0]        lsu_drain_addr,
`ifdef ORAM_DRAIN_ROWMASK_EN
  input  logic [ROWS-1:0]          lsu_drain_rowmask,
`endif
  output logic                     drain_done,
  input  logic                     mxu_data_rdy,
  input  logic [ROWS*BEAT_W-1:0]   mxu_int8_rows,
  input  logic [ROWS*2*BEAT_W-1:0] mxu_int16_rows,
  output logic                     drain_mxu_hold,
  output logic                     oram_wr_en,
  input  logic                     oram_wr_rdy,
  output logic [ADDR_W-1:0]        oram_wr_addr,
  output logic [BEAT_W-1:0]        oram_wr_data,
  output drain_state_t             dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid is held until then and the payload is stable while valid waits on ready.

  localparam int RW     = $clog2(ROWS);
  localparam int BIDX_W = RW + 1;

  drain_state_t      state_q, state_d;
  logic              int16_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [ROWS-1:0]   mask_q;
  logic [BIDX_W-1:0] b_q, sel_b;
  logic              en_q;
  logic [BEAT_W-1:0] data_q, sel_data;
  logic [RW:0]       cur_row, search_from, hit;
  logic              same_row_hi, last_beat, load, finish, accept;

  // Returns {found, row} for the lowest enabled row at or above 'from'.
  function automatic logic [RW:0] find_row(input logic [ROWS-1:0] m, input logic [RW:0] from);
    logic [RW:0] r;
    r = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = {1'b1, RW'(i)};
    end
    return r;
  endfunction

  // Next beat to present: the high half of the current int16 row, else the next enabled row.
  always_comb begin
    cur_row     = int16_q ? {1'b0, b_q[BIDX_W-1:1]} : {1'b0, b_q[RW-1:0]};
    same_row_hi = int16_q && !b_q[0];
    search_from = en_q ? cur_row + 1'b1 : '0;
    hit         = find_row(mask_q, search_from);
    if (en_q && same_row_hi) begin
      sel_b = b_q + 1'b1;
    end else if (int16_q) begin
      sel_b = {hit[RW-1:0], 1'b0};
    end else begin
      sel_b = {1'b0, hit[RW-1:0]};
    end
    last_beat = !same_row_hi && !hit[RW];
  end

  oram_drain_rowsel #(
    .ROWS  (ROWS),
    .BEAT_W(BEAT_W),
    .BIDX_W(BIDX_W)
  ) u_rowsel (
    .beat_i      (sel_b),
    .mode_i      (int16_q),
    .int8_rows_i (mxu_int8_rows),
    .int16_rows_i(mxu_int16_rows),
    .data_o      (sel_data)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    accept  = (state_q == IDLE) && lsu_drain_vld;
    case (state_q)
      IDLE:  if (lsu_drain_vld) state_d = WAIT;
      WAIT:  if (mxu_data_rdy) state_d = (|mask_q) ? WRITE : DONE;
      WRITE: begin
        if (!en_q) begin
          load = 1'b1;
        end else if (oram_wr_rdy) begin
          if (last_beat) begin
            finish  = 1'b1;
            state_d = DONE;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      int16_q <= 1'b0;
      base_q  <= '0;
      mask_q  <= '0;
      b_q     <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        int16_q <= lsu_drain_int16;
        base_q  <= lsu_drain_addr;
        b_q     <= '0;
`ifdef ORAM_DRAIN_ROWMASK_EN
        mask_q  <= lsu_drain_rowmask;
`else
        mask_q  <= '1;
`endif
      end
      // Addresses stay packed: each issued beat takes the next word, wrapping silently.
      if (load) begin
        en_q   <= 1'b1;
        b_q    <= sel_b;
        addr_q <= en_q ? addr_q + 1'b1 : base_q;
        data_q <= sel_data;
      end else if (finish) begin
        en_q <= 1'b0;
      end
    end
  end

  assign lsu_drain_rdy  = (state_q == IDLE);
  assign drain_done     = (state_q == DONE);
  assign drain_mxu_hold = (state_q == WAIT) || (state_q == WRITE);
  assign oram_wr_en     = en_q;
  assign oram_wr_addr   = addr_q;
  assign oram_wr_data   = data_q;
  assign dbg_state_o    = state_q;

endmodule
